// File: rtl/alu_issue_queue_pkg.sv
// Shared opcode constants, latency-class boundary and FSM encoding for the ALU issue queue.
package alu_issue_queue_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_AND  = 5'b00000;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00001;
  localparam logic [OP_W-1:0] OP_XOR  = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SLL  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SRL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SRA  = 5'b00111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_MULH = 5'b01001;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01010;
  localparam logic [OP_W-1:0] OP_DIVU = 5'b01011;
  localparam logic [OP_W-1:0] OP_REM  = 5'b01100;
  localparam logic [OP_W-1:0] OP_REMU = 5'b01101;
  localparam logic [OP_W-1:0] OP_ABS  = 5'b01110;

  // Opcodes below this value complete after a fixed number of cycles.
  localparam logic [OP_W-1:0] OP_VAR_BASE = 5'b01000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  function automatic logic is_fixed_lat(input logic [OP_W-1:0] op);
    return op < OP_VAR_BASE;
  endfunction

endpackage

// File: rtl/alu_issue_queue_cmd_fifo.sv
// Command FIFO: power-of-two depth, head read without pop, count-derived full/empty flags.
module alu_cmd_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned DW    = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic             pop_i,
  output logic [DW-1:0]    head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/alu_issue_queue.sv
// Queues ALU commands, issues the head entry to the ALU, and holds its result until accepted.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned FIXED_LAT = 2,
  parameter  int unsigned TIMEOUT   = 255,
  localparam int unsigned OCC_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_rs1_signed,
  input  logic             cmd_rs2_signed,
  output logic             alu_start,
  output logic [4:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_rs1_signed,
  output logic             alu_rs2_signed,
  input  logic             alu_busy,
  input  logic             alu_valid,
  input  logic [WIDTH-1:0] alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_timeout,
  output logic [OCC_W-1:0] occupancy
);

  localparam int unsigned ENTRY_W = OP_W + 2 * WIDTH + 2;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

  logic [ENTRY_W-1:0] fifo_wdata, fifo_head;
  logic               fifo_full, fifo_empty, fifo_pop;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load_head;
  logic               alu_start_q;
  logic [OP_W-1:0]    alu_op_q;
  logic [WIDTH-1:0]   alu_a_q, alu_b_q;
  logic               alu_s1_q, alu_s2_q;
  logic               res_valid_q, res_valid_d;
  logic               res_timeout_q, res_timeout_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;

  assign fifo_wdata = {cmd_op, cmd_a, cmd_b, cmd_rs1_signed, cmd_rs2_signed};

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    res_valid_d   = res_valid_q;
    res_timeout_d = res_timeout_q;
    res_data_d    = res_data_q;
    load_head     = 1'b0;
    fifo_pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !alu_busy) begin
          state_d   = S_ISSUE;
          load_head = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A legitimate capture wins over an abort landing on the same cycle.
        if (is_fixed_lat(alu_op_q) ? (cnt_q == CNT_W'(FIXED_LAT - 1)) : alu_valid) begin
          state_d     = S_HOLD;
          res_valid_d = 1'b1;
          res_data_d  = alu_result;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d       = S_HOLD;
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b1;
          res_data_d    = '0;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d       = S_IDLE;
          fifo_pop      = 1'b1;
          res_valid_d   = 1'b0;
          res_timeout_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      alu_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_start_q   <= (state_d == S_ISSUE);
      res_valid_q   <= res_valid_d;
      res_timeout_q <= res_timeout_d;
      res_data_q    <= res_data_d;
    end
  end

  // Head fields are latched at issue so they stay put until the entry pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_s1_q <= 1'b0;
      alu_s2_q <= 1'b0;
    end else if (load_head) begin
      {alu_op_q, alu_a_q, alu_b_q, alu_s1_q, alu_s2_q} <= fifo_head;
    end
  end

  assign cmd_ready      = !fifo_full;
  assign alu_start      = alu_start_q;
  assign alu_op         = alu_op_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_rs1_signed = alu_s1_q;
  assign alu_rs2_signed = alu_s2_q;
  assign res_valid      = res_valid_q;
  assign res_timeout    = res_timeout_q;
  assign res_data       = res_data_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: queue-based reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_alu_issue_queue;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 4;
  localparam int FIXED_LAT = 2;
  localparam int TIMEOUT   = 255;
  localparam int OCC_W     = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid, cmd_ready;
  logic [4:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic             cmd_rs1_signed, cmd_rs2_signed;
  logic             alu_start;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_rs1_signed, alu_rs2_signed;
  logic             alu_busy, alu_valid;
  logic [WIDTH-1:0] alu_result;
  logic             res_valid, res_ready, res_timeout;
  logic [WIDTH-1:0] res_data;
  logic [OCC_W-1:0] occupancy;

  logic             use_ovr;
  logic [WIDTH-1:0] ovr_res;

  always #5 clk = ~clk;

  alu_issue_queue #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FIXED_LAT(FIXED_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_rs1_signed(cmd_rs1_signed), .cmd_rs2_signed(cmd_rs2_signed),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_rs1_signed(alu_rs1_signed), .alu_rs2_signed(alu_rs2_signed),
    .alu_busy(alu_busy), .alu_valid(alu_valid), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .occupancy(occupancy)
  );

  // Simple ALU stand-in: adds the operands unless a result is being forced.
  assign alu_result = use_ovr ? ovr_res : (alu_a + alu_b);

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start = 0;
  int last_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && alu_start) begin
      n_start    = n_start + 1;
      last_start = cyc;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a command queue plus the age of the in-flight op in cycles since its start pulse.
  typedef struct {
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s1;
    logic             s2;
  } mcmd_t;

  mcmd_t            mq[$];
  int               m_age  = -1;
  bit               m_hold = 1'b0;
  bit               m_to   = 1'b0;
  logic [WIDTH-1:0] m_data = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_age  = -1;
      m_hold = 1'b0;
      m_to   = 1'b0;
      m_data = '0;
    end else begin : model_step
      bit    do_pop, do_push, fixed;
      mcmd_t c;
      do_pop  = m_hold && res_ready;
      do_push = cmd_valid && (mq.size() < DEPTH);
      if (m_hold) begin
        if (res_ready) m_hold = 1'b0;
      end else if (m_age >= 0) begin
        fixed = (mq[0].op < 5'b01000);
        if (m_age >= 1 && ((fixed && m_age == FIXED_LAT) || (!fixed && alu_valid))) begin
          m_hold = 1'b1;
          m_to   = 1'b0;
          m_data = alu_result;
        end else if (m_age == TIMEOUT) begin
          m_hold = 1'b1;
          m_to   = 1'b1;
          m_data = '0;
        end
        m_age = m_hold ? -1 : m_age + 1;
      end else if (mq.size() > 0 && !alu_busy) begin
        m_age = 0;
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        c.op = cmd_op; c.a = cmd_a; c.b = cmd_b;
        c.s1 = cmd_rs1_signed; c.s2 = cmd_rs2_signed;
        mq.push_back(c);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("occupancy", 64'(occupancy), 64'(mq.size()));
      check("cmd_ready", 64'(cmd_ready), 64'(mq.size() < DEPTH));
      check("alu_start", 64'(alu_start), 64'(m_age == 0));
      check("res_valid", 64'(res_valid), 64'(m_hold));
      check("res_timeout", 64'(res_timeout), 64'(m_hold && m_to));
      if (m_hold) check("res_data", 64'(res_data), 64'(m_data));
      if ((m_age >= 0 || m_hold) && mq.size() > 0) begin
        check("alu_op", 64'(alu_op), 64'(mq[0].op));
        check("alu_a", 64'(alu_a), 64'(mq[0].a));
        check("alu_b", 64'(alu_b), 64'(mq[0].b));
        check("alu_rs1_signed", 64'(alu_rs1_signed), 64'(mq[0].s1));
        check("alu_rs2_signed", 64'(alu_rs2_signed), 64'(mq[0].s2));
      end
    end
  end

  task automatic push_cmd(input logic [4:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s1, input logic s2);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    cmd_rs1_signed = s1; cmd_rs2_signed = s2;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin : stim
    bit ok;
    int n_rv;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_rs1_signed = 1'b0; cmd_rs2_signed = 1'b0;
    alu_busy = 1'b0; alu_valid = 1'b0; use_ovr = 1'b0; ovr_res = '0; res_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_alu_start", 64'(alu_start), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_timeout", 64'(res_timeout), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single fixed-latency ADD
    res_ready = 1'b1;
    n_start = 0;
    push_cmd(5'b00011, 32'd5, 32'd7, 1'b1, 1'b0);
    wait_res(20, ok);
    check("add_done", 64'(ok), 64'd1);
    check("add_data", 64'(res_data), 64'd12);
    check("add_timeout", 64'(res_timeout), 64'd0);
    check("add_latency", 64'(cyc - last_start), 64'(FIXED_LAT + 1));
    repeat (4) @(negedge clk);
    check("add_start_count", 64'(n_start), 64'd1);

    // Fill the FIFO with a fifth command offered while full
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 5'b00011;
      cmd_a = 32'(i * 16); cmd_b = 32'(i + 1);
      cmd_rs1_signed = 1'(i); cmd_rs2_signed = 1'b1;
      @(negedge clk);
      if (i == 3) begin
        check("full_occupancy", 64'(occupancy), 64'd4);
        check("full_cmd_ready", 64'(cmd_ready), 64'd0);
      end
    end
    cmd_valid = 1'b0;
    check("full_fifth_held", 64'(occupancy), 64'd4);

    // Push and result handshake together while full: only the pop happens
    wait_res(20, ok);
    check("full_res_done", 64'(ok), 64'd1);
    check("full_res_data", 64'(res_data), 64'd1);
    cmd_valid = 1'b1; cmd_op = 5'b00011; cmd_a = 32'h99; cmd_b = 32'd1;
    res_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; res_ready = 1'b0;
    check("pop_only_occupancy", 64'(occupancy), 64'd3);
    check("pop_only_cmd_ready", 64'(cmd_ready), 64'd1);
    res_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (occupancy == '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("drain_done", 64'(ok), 64'd1);

    // Variable-latency op; a stray alu_valid while idle must be ignored
    use_ovr = 1'b1; ovr_res = 32'hDEAD;
    alu_valid = 1'b1;
    @(negedge clk);
    alu_valid = 1'b0;
    @(negedge clk);
    check("idle_valid_ignored", 64'(res_valid), 64'd0);
    push_cmd(5'b01001, 32'd3, 32'd4, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (alu_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("var_started", 64'(ok), 64'd1);
    repeat (20) @(negedge clk);
    ovr_res = 32'h100; alu_valid = 1'b1;
    @(negedge clk);
    alu_valid = 1'b0;
    wait_res(5, ok);
    check("var_done", 64'(ok), 64'd1);
    check("var_data", 64'(res_data), 64'h100);
    check("var_timeout", 64'(res_timeout), 64'd0);
    check("var_latency", 64'(cyc - last_start), 64'd21);
    repeat (3) @(negedge clk);

    // Variable-latency op that never completes
    res_ready = 1'b0;
    push_cmd(5'b01010, 32'd9, 32'd9, 1'b1, 1'b1);
    wait_res(TIMEOUT + 20, ok);
    check("to_done", 64'(ok), 64'd1);
    check("to_latency", 64'(cyc - last_start), 64'(TIMEOUT + 1));
    check("to_data", 64'(res_data), 64'd0);
    check("to_flag", 64'(res_timeout), 64'd1);
    repeat (2) @(negedge clk);
    check("to_hold_valid", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("to_cleared", 64'(res_timeout), 64'd0);
    check("to_valid_dropped", 64'(res_valid), 64'd0);

    // Reset while waiting with three entries queued
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_op = 5'b01100; cmd_a = 32'(i + 40); cmd_b = 32'd2;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_occupancy", 64'(occupancy), 64'd3);
    rst = 1'b0;
    #1;
    check("mid_rst_occupancy", 64'(occupancy), 64'd0);
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_alu_start", 64'(alu_start), 64'd0);
    check("mid_rst_res_timeout", 64'(res_timeout), 64'd0);
    check("mid_rst_res_data", 64'(res_data), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    n_rv = 0;
    n_start = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) n_rv = n_rv + 1;
    end
    check("post_rst_no_result", 64'(n_rv), 64'd0);
    check("post_rst_no_start", 64'(n_start), 64'd0);
    check("post_rst_occupancy", 64'(occupancy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, got no end, expected end before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
